dcache_ctrl: RTL



---
 rtl/dcache_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hit path is combinational; misses walk MISS -> [WRITEBACK] -> READMISS -> READMISSOK.
module dcache_ctrl #(
    parameter int LINES  = 16,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_READMISS,
        S_READMISSOK
    } state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [2:0]        wsel;
    logic [LINE_W-1:0] line_rd;
    logic              req;
    logic              hit;
    logic              fill;
    logic              store_hit;
    logic              unused_addr_bits;

    assign idx              = cpu_addr_i[IDX_W+4:5];
    assign tag              = cpu_addr_i[ADDR_W-1:IDX_W+5];
    assign wsel             = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign line_rd          = data_q[idx];

    // MemRead together with MemWrite is a store, so only MemWrite selects the store path.
    assign req       = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit       = req & valid_q[idx] & (tag_q[idx] == tag);
    assign fill      = (state_q == S_READMISS) & mem_ack_i;
    assign store_hit = (state_q == S_IDLE) & hit & cpu_MemWrite_i;

    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b1;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            S_IDLE: begin
                cpu_stall_o = req & ~hit;
                if (hit & cpu_MemRead_i & ~cpu_MemWrite_i) begin
                    cpu_data_o = line_rd[wsel*32 +: 32];
                end
                if (req & ~hit) begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                state_d = (valid_q[idx] & dirty_q[idx]) ? S_WRITEBACK : S_READMISS;
            end
            S_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx], idx, 5'b0};
                mem_data_o   = line_rd;
                if (mem_ack_i) begin
                    state_d = S_READMISS;
                end
            end
            S_READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, 5'b0};
                if (mem_ack_i) begin
                    state_d = S_READMISSOK;
                end
            end
            S_READMISSOK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag/data are not reset; a fill acked during reset is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill) begin
                tag_q[idx]  <= tag;
                data_q[idx] <= mem_data_i;
            end else if (store_hit) begin
                data_q[idx][wsel*32 +: 32] <= cpu_data_i;
            end
        end
    end
endmodule
